mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- CPU-side agent on the byte-serial system memory bus (mem_a / mem_wr / mem_dout / mem_din), gated by rdy_in.
- Serves two internal word-level requesters: instruction fetch (IF) and load/store (MC).
- Serializes each request into little-endian byte transactions.
- Tolerates the one-cycle read latency of the RAM/IO responder and bus loss while rdy_in is low (debug break).

Parameters:
ADDR_WIDTH, 32, width of internal and bus byte addresses.

Ports:
clk_in  input  1  system clock; all state on rising edge
rst_in  input  1  reset, synchronous, active-high
rdy_in  input  1  bus grant; 0 = bus owned by debug host, controller frozen
if_req  input  1  fetch request, level, held until if_done
if_addr  input  ADDR_WIDTH  fetch byte address (always 4-byte read)
if_done  output  1  one-cycle pulse: if_data valid
if_data  output  32  fetched word, byte at if_addr in [7:0]
mc_req  input  1  data request, level, held until mc_done
mc_wr  input  1  1 = store, 0 = load
mc_len  input  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
mc_addr  input  ADDR_WIDTH  data byte address
mc_wdata  input  32  store data, byte i = bits [8i+7:8i]
mc_done  output  1  one-cycle pulse: access complete, mc_rdata valid for loads
mc_rdata  output  32  load data, zero-extended above mc_len bytes
busy  output  1  1 when not IDLE
mem_din  input  8  read byte from bus, valid the cycle after its address
mem_dout  output  8  write byte
mem_a  output  ADDR_WIDTH  byte address
mem_wr  output  1  1 = write

Behaviour:
Reset and idle:
- Reset (any cycle, including mid-transfer) forces IDLE. mem_a=0, mem_wr=0, mem_dout=0, if_done=0, mc_done=0, busy=0; if_data and mc_rdata = 0.
- An interrupted store emits no further bytes.
- All outputs are registered. In IDLE, mem_wr=0 and mem_a holds 0.

States: IDLE, READ, WRITE.
- IDLE -> READ/WRITE on an edge where rdy_in=1 and a request is high. Neither done output may be high in that cycle, so a held request cannot be re-accepted.
- Priority: mc_req beats if_req. Losing request stays pending.
- On accept, latch base address, length L (1/2/4), source, wdata. Set mem_a <= base.
  - Store: mem_wr <= 1, mem_dout <= byte 0.
- Counters: sent (bytes addressed) and recv (bytes captured), 0..4.

READ (each edge with rdy_in=1):
- If sent<L: mem_a <= base+sent, sent++.
- If the previous cycle presented a valid address: capture mem_din into byte recv, recv++.
- When recv reaches L: raise the source done for exactly one cycle with data, return to IDLE.
- Latency (accept edge = edge 0): addresses A..A+3 driven after edges 0..3; captures at edges 2..5; if_done high after edge 5. L-byte read done after edge L+1.

WRITE (each edge with rdy_in=1):
- Byte i is committed at that edge. Advance to byte i+1 (mem_a, mem_dout).
- After byte L-1 commits: mem_wr <= 0, mc_done <= 1, IDLE. L-byte store done after edge L.

Stall (any edge with rdy_in=0):
- No byte is captured or committed and no done is raised.
- READ: sent <= recv, in-flight marked invalid, mem_a <= base+recv. Resumes from the lowest uncaptured byte.
- WRITE: current byte re-presented unchanged.
- IDLE: no accept.

Address arithmetic:
- base+i wraps modulo 2^ADDR_WIDTH.
- No alignment requirement; I/O addresses are treated identically.

Test Plan:
- Word fetch: if_req, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> mem_a 0x100..0x103 on consecutive cycles, mem_wr=0, if_done one cycle after edge 5, if_data=0x00100513.
- Byte/half/word stores: mc_wr=1, mc_addr=0x200, mc_wdata=0xDEADBEEF, mc_len=0/1/3 -> bytes EF / EF,BE / EF,BE,AD,DE written to 0x200+; mc_done after edge 1/2/4; no write beyond L.
- Half load zero-extend: memory 0x300 = 0xFF,0x80 -> mc_rdata=0x000080FF, mc_done after edge 3.
- Simultaneous if_req and mc_req in IDLE -> MC load serviced first. Fetch starts the edge after mc_done clears. Each done pulses exactly once.
- rdy_in low for 3 cycles mid word read after byte 1 captured -> no capture during stall; after resume mem_a restarts at base+2; final data is correct.
- rdy_in low mid store at byte 2 -> same byte held, written once after resume.
- rst_in asserted at the 2nd byte of a word store -> next cycle mem_wr=0, busy=0, no done. Bytes 2 and 3 unchanged in memory.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory bus master that turns fetch and load/store word
// requests into little-endian byte transactions, freezing while rdy_in is low.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  mc_req,
    input  logic                  mc_wr,
    input  logic [1:0]            mc_len,
    input  logic [ADDR_WIDTH-1:0] mc_addr,
    input  logic [31:0]           mc_wdata,
    output logic                  mc_done,
    output logic [31:0]           mc_rdata,
    output logic                  busy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, mem_a_q, mem_a_d;
    logic [2:0]            len_q, len_d, sent_q, sent_d, recv_q, recv_d;
    logic                  src_mc_q, src_mc_d, mem_wr_q, mem_wr_d;
    logic                  v1_q, v1_d, v2_q, v2_d;
    logic [31:0]           wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic [31:0]           if_data_q, if_data_d, mc_rdata_q, mc_rdata_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  if_done_q, if_done_d, mc_done_q, mc_done_d;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [2:0]            acc_len;

    // a done still showing means its requester has not yet dropped the level request
    assign accept   = rdy_in && !if_done_q && !mc_done_q && (mc_req || if_req);
    assign acc_addr = mc_req ? mc_addr : if_addr;
    assign acc_len  = !mc_req ? 3'd4 : mc_len == 2'd0 ? 3'd1 : mc_len == 2'd1 ? 3'd2 : 3'd4;

    // v1: mem_a carries a fresh read address now; v2: it did one cycle ago, so mem_din holds its byte
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        src_mc_d   = src_mc_q;
        wdata_d    = wdata_q;
        sent_d     = sent_q;
        recv_d     = recv_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = mem_wr_q;
        mem_dout_d = mem_dout_q;
        if_data_d  = if_data_q;
        mc_rdata_d = mc_rdata_q;
        if_done_d  = 1'b0;
        mc_done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                base_d   = acc_addr;
                len_d    = acc_len;
                src_mc_d = mc_req;
                wdata_d  = mc_wdata;
                rbuf_d   = '0;
                recv_d   = '0;
                mem_a_d  = acc_addr;
                if (mc_req && mc_wr) begin
                    state_d    = WRITE;
                    mem_wr_d   = 1'b1;
                    mem_dout_d = mc_wdata[7:0];
                    sent_d     = '0;
                end else begin
                    state_d = READ;
                    sent_d  = 3'd1;
                    v1_d    = 1'b1;
                    v2_d    = 1'b0;
                end
            end
        end else if (!rdy_in) begin
            if (state_q == READ) begin
                sent_d  = recv_q;
                v1_d    = 1'b0;
                v2_d    = 1'b0;
                mem_a_d = base_q + ADDR_WIDTH'(recv_q);
            end
        end else if (state_q == READ) begin
            v1_d = sent_q < len_q;
            v2_d = v1_q;
            if (sent_q < len_q) begin
                mem_a_d = base_q + ADDR_WIDTH'(sent_q);
                sent_d  = sent_q + 3'd1;
            end
            if (v2_q) begin
                rbuf_d[8*recv_q[1:0] +: 8] = mem_din;
                recv_d = recv_q + 3'd1;
                if (recv_d == len_q) begin
                    state_d    = IDLE;
                    mem_a_d    = '0;
                    sent_d     = '0;
                    recv_d     = '0;
                    v1_d       = 1'b0;
                    v2_d       = 1'b0;
                    if_done_d  = !src_mc_q;
                    mc_done_d  = src_mc_q;
                    if_data_d  = src_mc_q ? if_data_q : rbuf_d;
                    mc_rdata_d = src_mc_q ? rbuf_d : mc_rdata_q;
                end
            end
        end else if (sent_q + 3'd1 == len_q) begin
            state_d    = IDLE;
            mem_wr_d   = 1'b0;
            mem_a_d    = '0;
            mem_dout_d = '0;
            sent_d     = '0;
            mc_done_d  = 1'b1;
        end else begin
            sent_d     = sent_q + 3'd1;
            mem_a_d    = base_q + ADDR_WIDTH'(sent_d);
            mem_dout_d = wdata_q[8*sent_d[1:0] +: 8];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            src_mc_q   <= 1'b0;
            wdata_q    <= '0;
            sent_q     <= '0;
            recv_q     <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
            if_data_q  <= '0;
            mc_rdata_q <= '0;
            if_done_q  <= 1'b0;
            mc_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            src_mc_q   <= src_mc_d;
            wdata_q    <= wdata_d;
            sent_q     <= sent_d;
            recv_q     <= recv_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            if_data_q  <= if_data_d;
            mc_rdata_q <= mc_rdata_d;
            if_done_q  <= if_done_d;
            mc_done_q  <= mc_done_d;
        end
    end

    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign mc_done  = mc_done_q;
    assign mc_rdata = mc_rdata_q;
    assign busy     = state_q != IDLE;
    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;
endmodule
